// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter
// Shares one AES-128 core (no start/done handshake) between requesters A and B
// with round-robin arbitration. An accepted request latches plaintext and key,
// pulses core_rst for one cycle to start the core, waits CORE_LATENCY cycles,
// and then captures core_finalout as the winner's response.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   a_valid/a_ready/a_data/a_key     requester A request channel
//   a_resp_valid/a_resp_ready/a_resp_data  requester A response channel
//   b_*                         same as A, for requester B
//   core_rst                    reset/start pulse to the core
//   core_datain, core_key       registered plaintext and key to the core
//   core_finalout               ciphertext from the core
//   a_done_cnt, b_done_cnt      saturating response counters (AES_ARB_CNT_EN only)
//
// Optional feature macro: AES_ARB_CNT_EN adds the per-requester completed
// response counters. Without it the ports and counters are absent.
module aes_core_arbiter #(
  parameter int CORE_LATENCY = 12,
  parameter int DATA_W       = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [DATA_W-1:0] a_data,
  input  logic [DATA_W-1:0] a_key,
  output logic              a_resp_valid,
  input  logic              a_resp_ready,
  output logic [DATA_W-1:0] a_resp_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [DATA_W-1:0] b_data,
  input  logic [DATA_W-1:0] b_key,
  output logic              b_resp_valid,
  input  logic              b_resp_ready,
  output logic [DATA_W-1:0] b_resp_data,
  output logic              core_rst,
  output logic [DATA_W-1:0] core_datain,
  output logic [DATA_W-1:0] core_key,
  input  logic [DATA_W-1:0] core_finalout
`ifdef AES_ARB_CNT_EN
  ,
  output logic [15:0]       a_done_cnt,
  output logic [15:0]       b_done_cnt
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] RESP = 2'd3;

  localparam logic [7:0] CNT_LOAD = 8'(CORE_LATENCY - 1);

  logic [1:0] state;
  logic       last_grant;   // 1'b1 = B won most recently; also the current owner
  logic [7:0] cnt;
  logic       grant_a;
  logic       grant_b;
  logic       a_resp_hs;
  logic       b_resp_hs;

  // Round-robin pick: a lone requester always wins; on contention the side
  // that did not win last time is chosen.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_valid && b_valid) begin
      grant_a = last_grant;
      grant_b = ~last_grant;
    end else begin
      grant_a = a_valid;
      grant_b = b_valid;
    end
  end

  assign a_ready   = (state == IDLE) & grant_a;
  assign b_ready   = (state == IDLE) & grant_b;
  assign a_resp_hs = a_resp_valid & a_resp_ready;
  assign b_resp_hs = b_resp_valid & b_resp_ready;

  // The core is held in reset with the system, and pulsed for the single LOAD
  // cycle to start a run on the freshly latched operands.
  assign core_rst = rst | (state == LOAD);

  // Arbitration FSM, operand latches, latency counter and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cnt          <= 8'd0;
      core_datain  <= {DATA_W{1'b0}};
      core_key     <= {DATA_W{1'b0}};
      a_resp_valid <= 1'b0;
      b_resp_valid <= 1'b0;
      a_resp_data  <= {DATA_W{1'b0}};
      b_resp_data  <= {DATA_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (a_valid && a_ready) begin
            core_datain <= a_data;
            core_key    <= a_key;
            last_grant  <= 1'b0;
            state       <= LOAD;
          end else if (b_valid && b_ready) begin
            core_datain <= b_data;
            core_key    <= b_key;
            last_grant  <= 1'b1;
            state       <= LOAD;
          end
        end
        LOAD: begin
          cnt   <= CNT_LOAD;
          state <= RUN;
        end
        RUN: begin
          // cnt reaches zero exactly CORE_LATENCY cycles after core_rst drops
          if (cnt == 8'd0) begin
            if (last_grant) begin
              b_resp_data  <= core_finalout;
              b_resp_valid <= 1'b1;
            end else begin
              a_resp_data  <= core_finalout;
              a_resp_valid <= 1'b1;
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RESP: begin
          if (last_grant) begin
            if (b_resp_hs) begin
              b_resp_valid <= 1'b0;
              state        <= IDLE;
            end
          end else begin
            if (a_resp_hs) begin
              a_resp_valid <= 1'b0;
              state        <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef AES_ARB_CNT_EN
  // Completed-response counters, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_done_cnt <= 16'd0;
      b_done_cnt <= 16'd0;
    end else begin
      if (a_resp_hs && (a_done_cnt != 16'hFFFF)) begin
        a_done_cnt <= a_done_cnt + 16'd1;
      end
      if (b_resp_hs && (b_done_cnt != 16'hFFFF)) begin
        b_done_cnt <= b_done_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
